i2s_tx_sched: RTL and testbench
===============================

// Module: i2s_tx_sched
// PURPOSE
//  Sequencer for the I2S transmit path: generates bclk/wclk from clk with programmable dividers.
//  Buffers producer samples in a 2-entry FIFO (valid/ready) and presents one L/R pair per frame
//  on tx_data_l/tx_data_r/tx_data_valid, stable for the whole frame; feeds i2s_tx directly.
//  Handles start/stop sequencing, mute insertion on underrun and underrun counting.
// PARAMETERS
//  SAMPLE_DEPTH  16  bits per channel sample
//  BCLK_DIV      4   clk cycles per bclk half-period (>=1)
//  BITS_PER_CH   32  bclk periods per wclk half-period (>=SAMPLE_DEPTH)
//  UFLOW_W       16  width of underrun counter
// PORTS
//  clk            in   1             single clock; every register on posedge clk
//  reset          in   1             asynchronous, active-low (0 = reset)
//  enable         in   1             1 = run/continue framing, 0 = stop at end of current frame
//  in_l           in   SAMPLE_DEPTH  left sample from producer
//  in_r           in   SAMPLE_DEPTH  right sample from producer
//  in_valid       in   1             producer has a pair
//  in_ready       out  1             FIFO can accept (registered)
//  bclk           out  1             bit clock (registered)
//  wclk           out  1             word clock, 0 = left, 1 = right (registered)
//  tx_data_l      out  SAMPLE_DEPTH  left sample for current frame
//  tx_data_r      out  SAMPLE_DEPTH  right sample for current frame
//  tx_data_valid  out  1             1 = real sample this frame, 0 = muted (underrun)
//  frame_start    out  1             one-clk pulse at each frame boundary
//  running        out  1             1 in RUN or STOP state
//  underrun_cnt   out  UFLOW_W       saturating count of muted frames
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: all outputs 0 except in_ready=1 once released; FIFO flushed; state IDLE; counters 0.
//  FSM: IDLE -> RUN when enable=1. RUN -> STOP when enable=0. STOP -> RUN when enable=1
//   (no gap, framing continues). STOP -> IDLE at the next frame boundary (no pop there).
//  IDLE: bclk=wclk=0, div_cnt=bit_cnt=0, no pops; FIFO still accepts, so it can be prefilled.
//  Divider: div_cnt counts 0..BCLK_DIV-1; bclk toggles when div_cnt==BCLK_DIV-1.
//   Falling bclk advances bit_cnt 0..2*BITS_PER_CH-1 with wrap.
//   wclk = (bit_cnt >= BITS_PER_CH), updated on the same cycle as the bclk fall.
//  Frame = 4*BCLK_DIV*BITS_PER_CH clk cycles (512 with defaults).
//  frame_start: pulses on the first clk of RUN and on each bit_cnt wrap while in RUN/STOP.
//   A wrap in STOP goes to IDLE instead of pulsing.
//  On frame_start cycle (registered, visible next clk):
//   - FIFO non-empty: pop head -> tx_data_l/r, tx_data_valid=1.
//   - FIFO empty: tx_data_l/r=0, tx_data_valid=0, underrun_cnt+1 (saturates at all-ones).
//  tx_data_* holds unchanged between frame_starts and in IDLE.
//  FIFO: 2 entries, first in first out. in_ready = (count<2), registered from next-state count.
//   Push when in_valid & in_ready. Simultaneous push+pop at count 1 keeps count 1 and preserves order.
//   At count 2, in_ready=0, so no push can coincide with a full FIFO.
//  underrun_cnt cleared only by reset. running = state!=IDLE.
//  Reset mid-frame: asynchronously forces every output and the FIFO to reset values at once.
// TESTING
//  1 Prefill (L=0x0002,R=0x0003), enable=1 -> frame_start at RUN entry, tx_data=2/3, valid=1,
//    bclk period 8 clk, wclk rises 256 clk after frame_start, next frame_start at +512.
//  2 enable=1, no input -> tx_data=0, valid=0, underrun_cnt=1,2,...
//    With UFLOW_W=2: stays 3 after the 4th muted frame.
//  3 in_valid held with 3 pairs in IDLE -> in_ready low after 2 accepted.
//    Third pair accepted the clk after the first frame_start; pop order preserved.
//  4 enable=0 at clk 100 of a frame -> frame completes, bclk=wclk=0 and running=0 from clk 512,
//    queued pair remains. Re-raise enable at clk 300 instead -> next frame_start at 512, no gap.
//  5 reset=0 at clk 300 mid-frame -> all outputs 0 within the same cycle, FIFO empty,
//    underrun_cnt=0; after release framing restarts only on enable.
//  6 BCLK_DIV=1, BITS_PER_CH=16 -> bclk period 2 clk, frame_start every 64 clk, wclk high clk 32..63.

Source files
------------

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: I2S transmit sequencer. Derives bclk/wclk from clk, buffers
// producer L/R pairs in a 2-entry FIFO and presents one pair per frame,
// muting and counting underruns when the FIFO is empty at a frame boundary.
module i2s_tx_sched #(
  parameter int SAMPLE_DEPTH = 16,
  parameter int BCLK_DIV     = 4,
  parameter int BITS_PER_CH  = 32,
  parameter int UFLOW_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_DEPTH-1:0] in_l,
  input  logic [SAMPLE_DEPTH-1:0] in_r,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    bclk,
  output logic                    wclk,
  output logic [SAMPLE_DEPTH-1:0] tx_data_l,
  output logic [SAMPLE_DEPTH-1:0] tx_data_r,
  output logic                    tx_data_valid,
  output logic                    frame_start,
  output logic                    running,
  output logic [UFLOW_W-1:0]      underrun_cnt
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * BITS_PER_CH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * BITS_PER_CH - 1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(BITS_PER_CH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  // Underrun counter sticks at all-ones instead of wrapping.
  function automatic logic [UFLOW_W-1:0] sat_inc(input logic [UFLOW_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    bclk_q, bclk_d;
  logic                    wclk_q, wclk_d;
  logic                    fs_q, fs_d;
  logic                    wrap;

  logic [SAMPLE_DEPTH-1:0] mem_l_q [2];
  logic [SAMPLE_DEPTH-1:0] mem_r_q [2];
  logic [SAMPLE_DEPTH-1:0] mem_l_d [2];
  logic [SAMPLE_DEPTH-1:0] mem_r_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    in_ready_q, in_ready_d;
  logic                    push, pop;

  logic [SAMPLE_DEPTH-1:0] tx_l_q, tx_l_d;
  logic [SAMPLE_DEPTH-1:0] tx_r_q, tx_r_d;
  logic                    tx_v_q, tx_v_d;
  logic [UFLOW_W-1:0]      uflow_q, uflow_d;

  // Next-state logic for the run/stop FSM and the bclk/wclk divider chain.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    wclk_d    = wclk_q;
    fs_d      = 1'b0;
    wrap      = 1'b0;
    if (state_q == S_IDLE) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      bclk_d    = 1'b0;
      wclk_d    = 1'b0;
      if (enable) begin
        state_d = S_RUN;
        fs_d    = 1'b1;
      end
    end else begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        bclk_d    = ~bclk_q;
        if (bclk_q) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            wrap      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          wclk_d = (bit_cnt_d >= BIT_HALF);
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
      if (state_q == S_RUN) begin
        if (!enable) state_d = S_STOP;
        fs_d = wrap;
      end else if (enable) begin
        // Re-enabled during the draining frame: keep framing without a gap.
        state_d = S_RUN;
        fs_d    = wrap;
      end else if (wrap) begin
        // Stopped frame ends: return to idle without popping.
        state_d   = S_IDLE;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        bclk_d    = 1'b0;
        wclk_d    = 1'b0;
      end
    end
  end

  // FIFO bookkeeping, per-frame sample presentation and underrun counting.
  always_comb begin
    push       = in_valid & in_ready_q;
    pop        = fs_q & (count_q != 2'd0);
    mem_l_d    = mem_l_q;
    mem_r_d    = mem_r_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_l_d     = tx_l_q;
    tx_r_d     = tx_r_q;
    tx_v_d     = tx_v_q;
    uflow_d    = uflow_q;
    if (push) begin
      mem_l_d[wr_ptr_q] = in_l;
      mem_r_d[wr_ptr_q] = in_r;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (fs_q) begin
      if (pop) begin
        tx_l_d   = mem_l_q[rd_ptr_q];
        tx_r_d   = mem_r_q[rd_ptr_q];
        tx_v_d   = 1'b1;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        tx_l_d  = '0;
        tx_r_d  = '0;
        tx_v_d  = 1'b0;
        uflow_d = sat_inc(uflow_q);
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d < 2'd2);
  end

  // Control and output registers; reset clears them asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      wclk_q     <= 1'b0;
      fs_q       <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      tx_v_q     <= 1'b0;
      uflow_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bclk_q     <= bclk_d;
      wclk_q     <= wclk_d;
      fs_q       <= fs_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      tx_l_q     <= tx_l_d;
      tx_r_q     <= tx_r_d;
      tx_v_q     <= tx_v_d;
      uflow_q    <= uflow_d;
    end
  end

  // FIFO storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_l_q <= mem_l_d;
    mem_r_q <= mem_r_d;
  end

  assign in_ready      = in_ready_q;
  assign bclk          = bclk_q;
  assign wclk          = wclk_q;
  assign tx_data_l     = tx_l_q;
  assign tx_data_r     = tx_r_q;
  assign tx_data_valid = tx_v_q;
  assign frame_start   = fs_q;
  assign running       = (state_q != S_IDLE);
  assign underrun_cnt  = uflow_q;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Bench for i2s_tx_sched: scoreboard of accepted pairs against per-frame
// outputs, plus framing timing checks on three parameterisations.
module tb_i2s_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- main instance (defaults) ----------------
  logic        rst_n, en, vld;
  logic [15:0] l, r;
  logic        rdy, bclk, wclk, txv, fs, run;
  logic [15:0] txl, txr, uf;

  i2s_tx_sched dut (
    .clk(clk), .reset(rst_n), .enable(en), .in_l(l), .in_r(r), .in_valid(vld),
    .in_ready(rdy), .bclk(bclk), .wclk(wclk), .tx_data_l(txl), .tx_data_r(txr),
    .tx_data_valid(txv), .frame_start(fs), .running(run), .underrun_cnt(uf)
  );

  // ---------------- narrow underrun counter instance ----------------
  logic        rst_u_n, en_u;
  logic        rdy_u, bclk_u, wclk_u, txv_u, fs_u, run_u;
  logic [15:0] txl_u, txr_u;
  logic [1:0]  uf_u;
  logic        done_u = 1'b0;

  i2s_tx_sched #(.UFLOW_W(2)) dut_u (
    .clk(clk), .reset(rst_u_n), .enable(en_u), .in_l(16'h0000), .in_r(16'h0000), .in_valid(1'b0),
    .in_ready(rdy_u), .bclk(bclk_u), .wclk(wclk_u), .tx_data_l(txl_u), .tx_data_r(txr_u),
    .tx_data_valid(txv_u), .frame_start(fs_u), .running(run_u), .underrun_cnt(uf_u)
  );

  // ---------------- fast framing instance ----------------
  logic        rst_f_n, en_f;
  logic        rdy_f, bclk_f, wclk_f, txv_f, fs_f, run_f;
  logic [15:0] txl_f, txr_f, uf_f;
  logic        done_f = 1'b0;

  i2s_tx_sched #(.BCLK_DIV(1), .BITS_PER_CH(16)) dut_f (
    .clk(clk), .reset(rst_f_n), .enable(en_f), .in_l(16'h0000), .in_r(16'h0000), .in_valid(1'b0),
    .in_ready(rdy_f), .bclk(bclk_f), .wclk(wclk_f), .tx_data_l(txl_f), .tx_data_r(txr_f),
    .tx_data_valid(txv_f), .frame_start(fs_f), .running(run_f), .underrun_cnt(uf_f)
  );

  // ---------------- scoreboard monitor for the main instance ----------------
  logic [31:0] sb[$];
  int          last_fs = -1;
  int          last_bclk = -1;
  logic        prev_bclk = 1'b0;
  logic        prev_wclk = 1'b0;
  bit          pend = 1'b0;
  logic [15:0] pl, pr;
  logic        pv;
  int          exp_uf = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_uf    = 0;
      pend      = 1'b0;
      last_fs   = -1;
      last_bclk = -1;
      prev_bclk = 1'b0;
      prev_wclk = 1'b0;
    end else begin
      if (pend) begin
        check("tx_valid", txv, pv);
        check("tx_l", txl, pl);
        check("tx_r", txr, pr);
        check("underrun_cnt", uf, exp_uf);
        pend = 1'b0;
      end
      if (!run) begin
        last_fs   = -1;
        last_bclk = -1;
      end
      if (fs) begin
        if (last_fs >= 0) check("frame_period", cyc - last_fs, 512);
        last_fs = cyc;
        if (sb.size() > 0) begin
          {pl, pr} = sb.pop_front();
          pv = 1'b1;
        end else begin
          pl = 16'h0; pr = 16'h0; pv = 1'b0;
          exp_uf++;
        end
        pend = 1'b1;
      end
      if (bclk && !prev_bclk) begin
        if (last_bclk >= 0) check("bclk_period", cyc - last_bclk, 8);
        last_bclk = cyc;
      end
      if (wclk && !prev_wclk) check("wclk_rise", cyc - last_fs, 256);
      if (vld && rdy) sb.push_back({l, r});
      prev_bclk = bclk;
      prev_wclk = wclk;
    end
  end

  // Present a pair and hold it until accepted; returns the acceptance cycle.
  task automatic send(input logic [15:0] a, input logic [15:0] b, output int acc);
    int k;
    l = a; r = b; vld = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!rdy && k < 3000);
    check("send_accept", rdy, 1);
    acc = cyc;
    @(posedge clk); #2;
    vld = 1'b0;
  endtask

  task automatic wait_fs(output int c);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!fs && k < 1000);
    check("fs_seen", fs, 1);
    c = cyc;
  endtask

  int a1, a2, a3;
  bit s3_done = 1'b0;

  // ---------------- main sequence ----------------
  initial begin
    int t_en, t_fs, t, k;
    rst_n = 1'b0; en = 1'b0; vld = 1'b0; l = '0; r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", rdy, 0);
    check("rst_bclk", bclk, 0);
    check("rst_wclk", wclk, 0);
    check("rst_running", run, 0);
    check("rst_valid", txv, 0);
    check("rst_uf", uf, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    check("in_ready_after_rst", rdy, 1);

    // Prefill one pair, then start framing.
    send(16'h0002, 16'h0003, t);
    en = 1'b1; t_en = cyc;
    wait_fs(t_fs);
    check("fs_at_run_entry", t_fs - t_en, 1);
    check("running_on", run, 1);

    // Three muted frames with no producer input.
    for (int i = 0; i < 3; i++) wait_fs(t_fs);
    @(negedge clk);
    check("uf_after_three", uf, 3);

    // Stop at clk 100 of the frame; queue a pair that must survive.
    repeat (99) @(posedge clk); #2;
    en = 1'b0;
    send(16'h0011, 16'h0022, t);
    k = 0;
    do begin @(negedge clk); k++; end while (run && k < 1000);
    check("stop_running", run, 0);
    check("stop_at_512", cyc - t_fs, 512);
    check("stop_bclk", bclk, 0);
    check("stop_wclk", wclk, 0);
    check("stop_fifo_not_full", rdy, 1);

    // Restart; drop enable at clk 100 and re-raise at clk 300: no gap.
    @(posedge clk); #2 en = 1'b1;
    wait_fs(t_fs);
    repeat (100) @(posedge clk); #2 en = 1'b0;
    repeat (200) @(posedge clk); #2 en = 1'b1;
    check("stop_still_running", run, 1);
    wait_fs(t);
    check("no_gap", t - t_fs, 512);

    // Mid-frame reset with a pair queued.
    @(posedge clk); #2;
    send(16'h0055, 16'h0066, k);
    repeat (298) @(posedge clk); #2;
    check("pre_rst_bclk", bclk, 1);
    check("pre_rst_wclk", wclk, 1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", rdy, 0);
    check("arst_bclk", bclk, 0);
    check("arst_wclk", wclk, 0);
    check("arst_tx_l", txl, 0);
    check("arst_tx_r", txr, 0);
    check("arst_valid", txv, 0);
    check("arst_fs", fs, 0);
    check("arst_running", run, 0);
    check("arst_uf", uf, 0);
    en = 1'b0;
    repeat (3) @(posedge clk); #2 rst_n = 1'b1;
    repeat (20) @(posedge clk); #2;
    check("idle_after_rst", run, 0);
    check("rdy_after_rst2", rdy, 1);

    // Three pairs offered in idle: two fit, third waits for the first pop.
    fork
      begin
        send(16'h0101, 16'h0202, a1);
        send(16'h0303, 16'h0404, a2);
        send(16'h0505, 16'h0606, a3);
        s3_done = 1'b1;
      end
    join_none
    repeat (6) @(posedge clk); #2;
    check("full_in_ready", rdy, 0);
    check("two_accepted", a2 - a1, 1);
    en = 1'b1;
    wait_fs(t_fs);
    k = 0;
    while (!s3_done && k < 100) begin @(negedge clk); k++; end
    check("third_sent", s3_done, 1);
    check("third_after_fs", a3 - t_fs, 1);
    wait_fs(t);
    wait_fs(t);
    @(negedge clk);
    check("uf_after_refill", uf, 0);

    k = 0;
    while (!(done_u && done_f) && k < 20000) begin @(negedge clk); k++; end
    check("aux_done", done_u && done_f, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // ---------------- saturating counter with UFLOW_W=2 ----------------
  initial begin
    int k;
    rst_u_n = 1'b0; en_u = 1'b0;
    repeat (2) @(posedge clk); #2 rst_u_n = 1'b1;
    @(posedge clk); #2 en_u = 1'b1;
    for (int i = 0; i < 5; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!fs_u && k < 1000);
      check("u_fs_seen", fs_u, 1);
      @(negedge clk);
      check("u_uf", uf_u, (i + 1 > 3) ? 3 : i + 1);
      check("u_valid", txv_u, 0);
    end
    done_u = 1'b1;
  end

  // ---------------- BCLK_DIV=1, BITS_PER_CH=16 framing ----------------
  initial begin
    int k;
    rst_f_n = 1'b0; en_f = 1'b0;
    repeat (2) @(posedge clk); #2 rst_f_n = 1'b1;
    @(posedge clk); #2 en_f = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!fs_f && k < 100);
    check("f_fs_seen", fs_f, 1);
    for (int i = 0; i < 64; i++) begin
      check("f_bclk", bclk_f, i % 2);
      check("f_wclk", wclk_f, (i >= 32) ? 1 : 0);
      check("f_fs", fs_f, (i == 0) ? 1 : 0);
      @(negedge clk);
    end
    check("f_fs_period", fs_f, 1);
    check("f_wclk_wrap", wclk_f, 0);
    done_f = 1'b1;
  end

endmodule
